// File: rtl/div_unit_pkg.sv
// Shared types for the RV32M iterative divider: operation encoding, FSM states
// and the operand width used by the execute stage.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package div_unit_pkg;

  localparam int DIV_DATA_SIZE = `DATA_SIZE;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // Bit 0 of the encoding marks the unsigned variants, bit 1 the remainder ones.
  function automatic logic op_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute-stage operand muxes and the divider.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int DATA_SIZE = DIV_DATA_SIZE
);

  logic                 start;
  div_op_t              op;
  logic [DATA_SIZE-1:0] dividend;
  logic [DATA_SIZE-1:0] divisor;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [DATA_SIZE-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output busy, done, result
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the
// divisor magnitude and shift the resulting quotient bit in at the bottom.
module div_unit_step #(
  parameter int DATA_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0] rem,
  input  logic [DATA_SIZE-1:0] quo,
  input  logic [DATA_SIZE-1:0] dvsr,
  output logic [DATA_SIZE-1:0] rem_nxt,
  output logic [DATA_SIZE-1:0] quo_nxt
);

  logic [DATA_SIZE:0] rem_sh;
  logic [DATA_SIZE:0] diff;
  logic               fits;

  // rem < dvsr is invariant, so the shifted remainder needs one extra bit and
  // the top bit of the difference is a clean borrow flag.
  always_comb begin
    rem_sh  = {rem, quo[DATA_SIZE-1]};
    diff    = rem_sh - {1'b0, dvsr};
    fits    = ~diff[DATA_SIZE];
    rem_nxt = fits ? diff[DATA_SIZE-1:0] : rem_sh[DATA_SIZE-1:0];
    quo_nxt = {quo[DATA_SIZE-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one quotient bit per clock,
// registered result with a one-cycle done pulse and a busy flag for stalls.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_SIZE = DIV_DATA_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_SIZE) + 1;
  localparam logic [DATA_SIZE-1:0] MIN_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

  div_state_t           state, state_nxt;
  logic [CNT_W-1:0]     count;
  logic                 done_q, done_nxt;
  logic                 busy_q, busy_nxt;
  logic                 load, step_en;

  logic [DATA_SIZE-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic                 is_rem_q, neg_quo_q, neg_rem_q;
  logic [DATA_SIZE-1:0] rem_nxt, quo_nxt;

  logic signed [DATA_SIZE-1:0] a_s, b_s;
  logic                 sgn, a_neg, b_neg, div0, ovf, special;
  logic [DATA_SIZE-1:0] a_mag, b_mag, fixed;

  function automatic logic [DATA_SIZE-1:0] apply_sign(
    input logic [DATA_SIZE-1:0] mag,
    input logic                 neg
  );
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Operand decode, evaluated while IDLE so the request can be latched at E0
  always_comb begin
    a_s     = bus.dividend;
    b_s     = bus.divisor;
    sgn     = op_is_signed(bus.op);
    a_neg   = sgn && a_s[DATA_SIZE-1];
    b_neg   = sgn && b_s[DATA_SIZE-1];
    a_mag   = a_neg ? -a_s : a_s;
    b_mag   = b_neg ? -b_s : b_s;
    div0    = (bus.divisor == '0);
    ovf     = sgn && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
    special = div0 || ovf;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    load      = 1'b0;
    step_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        step_en = 1'b1;
        if (count == CNT_W'(DATA_SIZE - 1)) state_nxt = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush overrides everything, including a same-cycle start
    if (bus.flush) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
      load      = 1'b0;
      step_en   = 1'b0;
    end
    busy_nxt = (state_nxt != IDLE) || done_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      busy_q <= busy_nxt;
      if (load)         count <= '0;
      else if (step_en) count <= count + CNT_W'(1);
    end
  end

  div_unit_step #(
    .DATA_SIZE (DATA_SIZE)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvsr    (dvsr_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign fixed = is_rem_q ? apply_sign(rem_q, neg_rem_q)
                          : apply_sign(quo_q, neg_quo_q);

  // Special cases preload their final values with sign fixup disabled, so
  // DONE handles every path the same way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (load) begin
        is_rem_q <= op_is_rem(bus.op);
        dvsr_q   <= b_mag;
        if (div0) begin
          quo_q     <= '1;
          rem_q     <= bus.dividend;
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else if (ovf) begin
          quo_q     <= MIN_NEG;
          rem_q     <= '0;
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else begin
          quo_q     <= a_mag;
          rem_q     <= '0;
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
        end
      end else if (step_en) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end
      if (done_nxt) result_q <= fixed;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: unsigned/signed results, special
// cases, latency/busy timing, flush, ignored start and mid-operation reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   lat;
  int   bcyc;
  logic saw_done;

  div_unit_if bus ();

  div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, lets edge E0 sample it, then withdraws start.
  task automatic do_start(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts edges after E0 until done, and cycles with busy=1 along the way.
  task automatic wait_done(input int max, output int edges, output int busy_cycles);
    edges       = 0;
    busy_cycles = bus.busy ? 1 : 0;
    while (!bus.done && edges < max) begin
      tick();
      edges++;
      if (bus.busy) busy_cycles++;
    end
  endtask

  // Full transaction: result, latency, then done must drop with busy.
  task automatic run_op(input string tag, input div_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int e;
    int bc;
    do_start(op, a, b);
    wait_done(60, e, bc);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_lat"}, 32'(e), 32'(exp_lat));
    chk({tag, "_busy_cyc"}, 32'(bc), 32'(exp_lat + 1));
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = OP_DIVU;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m20_3", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_op("rem_m20_3", OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_op("rem_20_m3", OP_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("remu_9_4", OP_REMU, 32'd9, 32'd4, 32'd1, 33);

    // Flush sampled at E10 aborts DIVU 1000/10; result keeps 1
    do_start(OP_DIVU, 32'd1000, 32'd10);
    saw_done = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    if (bus.done) saw_done = 1'b1;
    chk("flush_no_done", 32'(saw_done), 32'd0);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_result", bus.result, 32'd1);
    run_op("after_flush", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33);

    // Flush and start in the same IDLE cycle: request dropped
    bus.flush = 1'b1;
    do_start(OP_DIVU, 32'd50, 32'd5);
    bus.flush = 1'b0;
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("flush_start_done", 32'(bus.done), 32'd0);
    chk("flush_start_result", bus.result, 32'd100);

    // Start pulse while busy must be ignored
    do_start(OP_DIVU, 32'd77, 32'd7);
    tick();
    tick();
    tick();
    do_start(OP_REMU, 32'd9, 32'd4);
    wait_done(60, lat, bcyc);
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_lat", 32'(lat + 4), 32'd33);
    chk("ign_result", bus.result, 32'd11);
    tick();
    chk("ign_no_second", 32'(bus.busy), 32'd0);
    tick();
    chk("ign_no_second_done", 32'(bus.done), 32'd0);

    // Reset sampled at E5 of a division clears busy, done and result
    do_start(OP_DIV, 32'hFFFF_FFEC, 32'd3);
    for (int i = 1; i <= 4; i++) tick();
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    tick();
    run_op("after_rst", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
